// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: fetch FSM states, bubble instruction, halt opcode.
// Imported by fetch, decode and hazard logic.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] CPU_NOP_INSTR  = 16'h0000;
  localparam logic [3:0]  CPU_HLT_OPCODE = 4'hF;
  localparam logic [15:0] PC_STEP        = 16'd2;

  function automatic logic is_hlt(
    input logic [15:0] instr,
    input logic [3:0]  op
  );
    return instr[15:12] == op;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// pc_register: 16-bit program counter with write enable.
// Ports: clk, rst (async active-low), i_we, i_d -> o_q.
module pc_register #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);

  logic [15:0] r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (i_we) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, imem request/response, branch squash, HLT.
// Ports: clk/rst, stall, branch_*, imem_*, pc_out/instr_out/fd_enable, halted.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = CPU_NOP_INSTR,
  parameter logic [3:0]  HLT_OPCODE = CPU_HLT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] pc_out,
  output logic [15:0] instr_out,
  output logic        fd_enable,
  output logic        halted
);

  fetch_state_e r_state;
  fetch_state_e w_next;
  logic [15:0]  r_target;
  logic [15:0]  w_pc;
  logic [15:0]  w_pc_plus2;
  logic [15:0]  w_pc_d;
  logic         w_pc_we;
  logic         w_tgt_we;
  logic         w_present;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .i_we(w_pc_we),
    .i_d (w_pc_d),
    .o_q (w_pc)
  );

  assign w_pc_plus2 = w_pc + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FETCH;
      r_target <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_tgt_we) begin
        r_target <= branch_target;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pc_we   = 1'b0;
    w_pc_d    = w_pc_plus2;
    w_tgt_we  = 1'b0;
    w_present = 1'b0;
    unique case (r_state)
      S_FETCH, S_WAIT: begin
        if (branch_taken) begin
          // A miss already outstanding in WAIT must be drained
          // before the target can be requested.
          if (r_state == S_WAIT && !imem_valid) begin
            w_tgt_we = 1'b1;
            w_next   = S_DRAIN;
          end else begin
            w_pc_we = 1'b1;
            w_pc_d  = branch_target;
            w_next  = S_FETCH;
          end
        end else if (stall) begin
          w_next = r_state;
        end else if (imem_valid) begin
          w_present = 1'b1;
          w_pc_we   = 1'b1;
          w_next    = is_hlt(imem_rdata, HLT_OPCODE) ? S_HALT : S_FETCH;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (branch_taken) begin
          if (imem_valid) begin
            w_pc_we = 1'b1;
            w_pc_d  = branch_target;
            w_next  = S_FETCH;
          end else begin
            w_tgt_we = 1'b1;
          end
        end else if (!stall && imem_valid) begin
          w_pc_we = 1'b1;
          w_pc_d  = r_target;
          w_next  = S_FETCH;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
    endcase
  end

  // PC is held through WAIT/DRAIN, so it is the stale address to drain.
  assign imem_req  = (r_state != S_HALT);
  assign imem_addr = w_pc;
  assign pc_out    = w_pc_plus2;
  assign instr_out = (rst && w_present) ? imem_rdata : NOP_INSTR;
  assign fd_enable = ~stall;
  assign halted    = (r_state == S_HALT);

endmodule
